// File: rtl/store_trace_fifo_pkg.sv
// Shared widths, default sizing and the trace-entry layout for the store trace queue.
package store_trace_fifo_pkg;

    localparam int DEPTH_DEF   = 16;
    localparam int STAMP_W_DEF = 16;
    localparam int OVF_W_DEF   = 8;
    localparam int ADDR_W      = 5;
    localparam int DATA_W      = 32;

    // Field order matches the packed vector held in the storage array.
    typedef struct packed {
        logic [ADDR_W-1:0]      addr;
        logic [DATA_W-1:0]      data;
        logic [STAMP_W_DEF-1:0] stamp;
    } trace_entry_t;

endpackage

// File: rtl/trace_sync_fifo.sv
// Generic first-word-fall-through synchronous FIFO with flush; the head word is visible
// combinationally from the storage array whenever rd_valid is high.
module trace_sync_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop_req,
    output logic             rd_valid,
    output logic [WIDTH-1:0] rd_data,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_pop;
    logic             do_push;

    always_comb begin
        do_pop   = pop_req && (count_q != '0) && !flush;
        // A full queue still accepts a write when the head leaves on the same edge.
        do_push  = push && ((count_q != CNT_W'(DEPTH)) || do_pop) && !flush;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            if (do_push && !do_pop)      count_d = count_q + CNT_W'(1);
            else if (do_pop && !do_push) count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !reset) mem_q[wr_ptr_q] <= wr_data;
    end

    assign rd_valid = (count_q != '0);
    assign rd_data  = mem_q[rd_ptr_q];
    assign count    = count_q;
    assign full     = (count_q == CNT_W'(DEPTH));
    assign empty    = (count_q == '0);

endmodule

// File: rtl/store_trace_fifo.sv
// Captures CPU data-memory writes with a free-running cycle stamp into a FWFT trace queue,
// counting writes dropped because the queue was full.
module store_trace_fifo
    import store_trace_fifo_pkg::*;
#(
    parameter int DEPTH   = DEPTH_DEF,
    parameter int STAMP_W = STAMP_W_DEF,
    parameter int OVF_W   = OVF_W_DEF
) (
    input  logic                   clk_150MHz,
    input  logic                   reset,
    input  logic                   memwri,
    input  logic [ADDR_W-1:0]      dataaddr,
    input  logic [DATA_W-1:0]      datainm,
    input  logic                   enable,
    input  logic                   flush,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [ADDR_W-1:0]      out_addr,
    output logic [DATA_W-1:0]      out_data,
    output logic [STAMP_W-1:0]     out_stamp,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty,
    output logic [OVF_W-1:0]       ovf_cnt,
    output logic                   ovf_sticky
);

    localparam int ENTRY_W = ADDR_W + DATA_W + STAMP_W;

    logic [STAMP_W-1:0] stamp_q, stamp_d;
    logic [OVF_W-1:0]   ovf_cnt_q, ovf_cnt_d;
    logic               ovf_sticky_q, ovf_sticky_d;
    logic               capture;
    logic               drop;
    logic [ENTRY_W-1:0] wr_entry;
    logic [ENTRY_W-1:0] rd_entry;

    // Handshake: the head entry transfers on a rising edge where out_valid && out_ready;
    // out_valid never depends on out_ready and the head fields hold until that transfer.
    always_comb begin
        capture      = memwri && enable && !flush;
        drop         = capture && full && !out_ready;
        wr_entry     = {dataaddr, datainm, stamp_q};
        stamp_d      = stamp_q + STAMP_W'(1);
        ovf_cnt_d    = ovf_cnt_q;
        ovf_sticky_d = ovf_sticky_q;
        if (drop) begin
            ovf_sticky_d = 1'b1;
            if (ovf_cnt_q != '1) ovf_cnt_d = ovf_cnt_q + OVF_W'(1);
        end
    end

    always_ff @(posedge clk_150MHz) begin
        if (reset) begin
            stamp_q      <= '0;
            ovf_cnt_q    <= '0;
            ovf_sticky_q <= 1'b0;
        end else begin
            stamp_q      <= stamp_d;
            ovf_cnt_q    <= ovf_cnt_d;
            ovf_sticky_q <= ovf_sticky_d;
        end
    end

    trace_sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk      (clk_150MHz),
        .reset    (reset),
        .flush    (flush),
        .push     (capture),
        .wr_data  (wr_entry),
        .pop_req  (out_ready),
        .rd_valid (out_valid),
        .rd_data  (rd_entry),
        .count    (count),
        .full     (full),
        .empty    (empty)
    );

    assign out_addr   = rd_entry[ENTRY_W-1 -: ADDR_W];
    assign out_data   = rd_entry[STAMP_W +: DATA_W];
    assign out_stamp  = rd_entry[STAMP_W-1:0];
    assign ovf_cnt    = ovf_cnt_q;
    assign ovf_sticky = ovf_sticky_q;

endmodule
